// File: rtl/set_controller.sv
`default_nettype none
// ============================================================================
// Module      : set_controller
// Description : Time/date setting controller. Synchronizes and debounces the
//               mode/up/down buttons, walks the item being edited
//               (ss, mm, hh, dd, mo, yyyy, then back to run), issues
//               single-cycle up/down adjust pulses, returns to run after an
//               idle timeout and drives a blink enable for the selected item.
//               Optional macro AUTO_REPEAT_EN adds hold-to-repeat on up/down.
// Revision    : 1.0 - initial release
// ============================================================================
module set_controller #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16,
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter int BLINK_HALF      = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [2:0] select_item,
    output logic       up,
    output logic       down,
    output logic       editing,
    output logic       blink
);

    localparam logic [15:0] C_DEBOUNCE   = 16'(DEBOUNCE_CYCLES);
    localparam logic [15:0] C_TIMEOUT_M1 = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] C_BLINK_M1   = 16'(BLINK_HALF - 1);
    localparam logic [2:0]  C_ITEM_RUN   = 3'd7;
    localparam logic [2:0]  C_ITEM_LAST  = 3'd5;
    localparam int          C_MODE       = 0;
    localparam int          C_UP         = 1;
    localparam int          C_DOWN       = 2;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_EDIT = 1'b1
    } state_t;

    logic [2:0]  w_raw;
    logic [2:0]  r_sync1;
    logic [2:0]  r_sync2;
    logic [2:0]  r_deb;
    logic [2:0]  r_deb_q;
    logic [15:0] r_deb_cnt [3];
    logic [2:0]  w_rise;
    logic        w_both;
    logic        w_timeout;

    state_t      r_state;
    state_t      w_state_n;
    logic [2:0]  r_item;
    logic [2:0]  w_item_n;
    logic        r_up;
    logic        w_up_n;
    logic        r_down;
    logic        w_down_n;
    logic [15:0] r_idle;
    logic [15:0] w_idle_n;
    logic        r_blink;
    logic        w_blink_n;
    logic [15:0] r_bcnt;
    logic [15:0] w_bcnt_n;

`ifdef AUTO_REPEAT_EN
    localparam logic [15:0] C_REP_DELAY_M1  = 16'(REPEAT_DELAY - 1);
    localparam logic [15:0] C_REP_PERIOD_M1 = 16'(REPEAT_PERIOD - 1);

    logic        r_rep_act;
    logic        w_rep_act_n;
    logic        r_rep_first;
    logic        w_rep_first_n;
    logic        r_rep_dir;      // 0 = up, 1 = down
    logic        w_rep_dir_n;
    logic [15:0] r_rep_cnt;
    logic [15:0] w_rep_cnt_n;
    logic        w_rep_held;
`endif

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign w_raw     = {btn_down, btn_up, btn_mode};
    assign w_rise    = r_deb & ~r_deb_q;
    assign w_both    = r_deb[C_UP] & r_deb[C_DOWN];
    assign w_timeout = (r_state == ST_EDIT) && (r_deb == 3'b000) && (r_idle >= C_TIMEOUT_M1);

    // Two-flop synchronizers and debouncers; the level flips on the sample
    // following DEBOUNCE_CYCLES stable ones, so the action lands
    // 2+DEBOUNCE_CYCLES+1 cycles after the raw edge is first sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_deb_q <= '0;
            for (int i = 0; i < 3; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_deb_q <= r_deb;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] != r_deb[i]) begin
                    if (r_deb_cnt[i] >= C_DEBOUNCE) begin
                        r_deb[i]     <= r_sync2[i];
                        r_deb_cnt[i] <= '0;
                    end else begin
                        r_deb_cnt[i] <= sat_inc(r_deb_cnt[i]);
                    end
                end else begin
                    r_deb_cnt[i] <= '0;
                end
            end
        end
    end

    // Controller state, registered pulses, idle and blink counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_item  <= C_ITEM_RUN;
            r_up    <= 1'b0;
            r_down  <= 1'b0;
            r_idle  <= '0;
            r_blink <= 1'b0;
            r_bcnt  <= '0;
        end else begin
            r_state <= w_state_n;
            r_item  <= w_item_n;
            r_up    <= w_up_n;
            r_down  <= w_down_n;
            r_idle  <= w_idle_n;
            r_blink <= w_blink_n;
            r_bcnt  <= w_bcnt_n;
        end
    end

`ifdef AUTO_REPEAT_EN
    // Auto-repeat tracking for the button that produced the last press pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rep_act   <= 1'b0;
            r_rep_first <= 1'b0;
            r_rep_dir   <= 1'b0;
            r_rep_cnt   <= '0;
        end else begin
            r_rep_act   <= w_rep_act_n;
            r_rep_first <= w_rep_first_n;
            r_rep_dir   <= w_rep_dir_n;
            r_rep_cnt   <= w_rep_cnt_n;
        end
    end

    assign w_rep_held = r_rep_dir ? r_deb[C_DOWN] : r_deb[C_UP];
`endif

    // Next-state logic: item stepping, adjust pulses, repeat, timeout, blink.
    always_comb begin
        w_state_n = r_state;
        w_item_n  = r_item;
        w_up_n    = 1'b0;
        w_down_n  = 1'b0;
        w_idle_n  = sat_inc(r_idle);
        w_blink_n = r_blink;
        w_bcnt_n  = sat_inc(r_bcnt);
`ifdef AUTO_REPEAT_EN
        w_rep_act_n   = r_rep_act;
        w_rep_first_n = r_rep_first;
        w_rep_dir_n   = r_rep_dir;
        w_rep_cnt_n   = sat_inc(r_rep_cnt);
`endif

        // Any held button (a press implies held) keeps the idle timer cleared.
        if (r_deb != 3'b000) begin
            w_idle_n = '0;
        end

        // Mode wins over a coincident up/down press; chording up+down is ignored.
        if (w_rise[C_MODE]) begin
            if (r_state == ST_RUN) begin
                w_state_n = ST_EDIT;
                w_item_n  = 3'd0;
            end else if (r_item == C_ITEM_LAST) begin
                w_state_n = ST_RUN;
                w_item_n  = C_ITEM_RUN;
            end else begin
                w_item_n = r_item + 3'd1;
            end
        end else if ((r_state == ST_EDIT) && !w_both) begin
            if (w_rise[C_UP]) begin
                w_up_n = 1'b1;
            end else if (w_rise[C_DOWN]) begin
                w_down_n = 1'b1;
            end
        end

`ifdef AUTO_REPEAT_EN
        // A fresh press arms the repeat; anything that disturbs the hold cancels it.
        if (w_up_n || w_down_n) begin
            w_rep_act_n   = 1'b1;
            w_rep_first_n = 1'b1;
            w_rep_dir_n   = w_down_n;
            w_rep_cnt_n   = '0;
        end else if (r_rep_act) begin
            if (w_rise[C_MODE] || w_both || !w_rep_held || (r_state != ST_EDIT)) begin
                w_rep_act_n = 1'b0;
                w_rep_cnt_n = '0;
            end else if (r_rep_cnt >= (r_rep_first ? C_REP_DELAY_M1 : C_REP_PERIOD_M1)) begin
                w_up_n        = ~r_rep_dir;
                w_down_n      = r_rep_dir;
                w_rep_first_n = 1'b0;
                w_rep_cnt_n   = '0;
            end
        end
`endif

        // Idle timeout drops back to run and discards any pending pulse.
        if (w_timeout) begin
            w_state_n = ST_RUN;
            w_item_n  = C_ITEM_RUN;
            w_up_n    = 1'b0;
            w_down_n  = 1'b0;
`ifdef AUTO_REPEAT_EN
            w_rep_act_n = 1'b0;
            w_rep_cnt_n = '0;
`endif
        end

        // Blink restarts visible on any item change or adjust pulse.
        if (w_state_n == ST_RUN) begin
            w_blink_n = 1'b0;
            w_bcnt_n  = '0;
        end else if ((w_item_n != r_item) || w_up_n || w_down_n) begin
            w_blink_n = 1'b1;
            w_bcnt_n  = '0;
        end else if (r_bcnt >= C_BLINK_M1) begin
            w_blink_n = ~r_blink;
            w_bcnt_n  = '0;
        end
    end

    assign select_item = r_item;
    assign up          = r_up;
    assign down        = r_down;
    assign editing     = (r_state == ST_EDIT);
    assign blink       = r_blink;

endmodule
`default_nettype wire

// File: tb/tb_set_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_set_controller
// Description : Self-checking bench for set_controller. Pulse times are
//               computed from the button-to-action latency and the
//               repeat/timeout/blink rules, then compared with the logged
//               up/down pulses and sampled outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_set_controller;

    localparam int D   = 4;
    localparam int RD  = 20;
    localparam int RP  = 5;
    localparam int TO  = 100;
    localparam int BH  = 8;
    localparam int LAT = 2 + D + 1;   // raw edge to action, in cycles

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic [2:0] select_item;
    logic       up;
    logic       down;
    logic       editing;
    logic       blink;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int both_seen = 0;
    int q_up[$];
    int q_dn[$];

    set_controller #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .TIMEOUT_CYCLES (TO),
        .BLINK_HALF     (BH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_mode   (btn_mode),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .select_item(select_item),
        .up         (up),
        .down       (down),
        .editing    (editing),
        .blink      (blink)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse logger: records the cycle index in which each pulse is visible.
    always @(negedge clk) begin
        if (rst_n) begin
            if (up)   q_up.push_back(cyc);
            if (down) q_dn.push_back(cyc);
            if (up && down) both_seen++;
        end
    end

    function automatic int next_item(input int i);
        if (i == 7) return 0;
        if (i == 5) return 7;
        return i + 1;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0:       btn_mode = v;
            1:       btn_up   = v;
            default: btn_down = v;
        endcase
    endtask

    task automatic press(input int b, input int hold, input int gap, output int m);
        set_btn(b, 1'b1);
        m = cyc;
        step(hold);
        set_btn(b, 1'b0);
        step(gap);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        btn_mode = 1'b0;
        btn_up = 1'b0;
        btn_down = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(2);
        q_up.delete();
        q_dn.delete();
    endtask

    task automatic enter_items(input int n);
        int m;
        for (int k = 0; k < n; k++) press(0, 8, 15, m);
    endtask

    task automatic test_reset();
        int m;
        apply_reset();
        checks++;
        if (select_item !== 3'd7) begin errors++; $display("FAIL reset_item got %0d exp 7", select_item); end
        checks++;
        if (editing !== 1'b0 || blink !== 1'b0 || up !== 1'b0 || down !== 1'b0) begin
            errors++; $display("FAIL reset_outputs got ed=%b bl=%b up=%b dn=%b exp all 0", editing, blink, up, down);
        end
        press(0, 8, 3, m);
        rst_n = 1'b0;
        #2;
        checks++;
        if (select_item !== 3'd7 || editing !== 1'b0 || blink !== 1'b0) begin
            errors++; $display("FAIL async_reset got item=%0d ed=%b bl=%b exp 7/0/0", select_item, editing, blink);
        end
        step(2);
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_mode_step();
        int m;
        int exp_item;
        apply_reset();
        exp_item = 7;
        for (int k = 0; k < 7; k++) begin
            btn_mode = 1'b1;
            m = cyc;
            step(LAT);
            checks++;
            if (select_item !== 3'(exp_item)) begin errors++; $display("FAIL mode_early k=%0d got %0d exp %0d", k, select_item, exp_item); end
            step(1);
            exp_item = next_item(exp_item);
            checks++;
            if (select_item !== 3'(exp_item) || editing !== (exp_item != 7)) begin
                errors++; $display("FAIL mode_step k=%0d got %0d/%b exp %0d", k, select_item, editing, exp_item);
            end
            checks++;
            if (blink !== (exp_item != 7)) begin errors++; $display("FAIL blink_restart k=%0d got %b exp %b", k, blink, exp_item != 7); end
            step(2);
            btn_mode = 1'b0;
            if (k == 2) begin
                step(m + 1 + LAT + BH - cyc);
                checks++;
                if (blink !== 1'b0) begin errors++; $display("FAIL blink_half got %b exp 0", blink); end
                step(BH);
                checks++;
                if (blink !== 1'b1) begin errors++; $display("FAIL blink_full got %b exp 1", blink); end
            end
            step(12);
        end
    endtask

    task automatic test_glitch_press();
        int m;
        int g;
        apply_reset();
        enter_items(3);
        q_up.delete();
        q_dn.delete();
        g = int'($urandom_range(1, D));
        btn_up = 1'b1;
        step(g);
        btn_up = 1'b0;
        step(20);
        checks++;
        if (q_up.size() != 0) begin errors++; $display("FAIL glitch_pulse len=%0d got %0d pulses exp 0", g, q_up.size()); end
        press(1, 8, 20, m);
        checks++;
        if (q_up.size() != 1) begin
            errors++; $display("FAIL clean_press_count got %0d exp 1", q_up.size());
        end else begin
            checks++;
            if (q_up[0] != m + 1 + LAT) begin errors++; $display("FAIL clean_press_time got %0d exp %0d", q_up[0], m + 1 + LAT); end
        end
        checks++;
        if (q_dn.size() != 0 || select_item !== 3'd2) begin
            errors++; $display("FAIL clean_press_side got dn=%0d item=%0d exp 0/2", q_dn.size(), select_item);
        end
    endtask

    task automatic test_repeat();
        int m;
        int h;
        int exp_q[$];
        apply_reset();
        enter_items(1);
        for (int r = 0; r < 2; r++) begin
            h = (r == 0) ? 50 : int'($urandom_range(RD + 1, 60));
            q_up.delete();
            q_dn.delete();
            exp_q.delete();
            press(1, h, 25, m);
            exp_q.push_back(m + 1 + LAT);
`ifdef AUTO_REPEAT_EN
            for (int off = RD; off <= h - 1; off += RP) exp_q.push_back(m + 1 + LAT + off);
`endif
            checks++;
            if (q_up.size() != exp_q.size()) begin
                errors++; $display("FAIL repeat_count hold=%0d got %0d exp %0d", h, q_up.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < q_up.size(); i++) begin
                checks++;
                if (q_up[i] != exp_q[i]) begin errors++; $display("FAIL repeat_time hold=%0d i=%0d got %0d exp %0d", h, i, q_up[i], exp_q[i]); end
            end
            checks++;
            if (q_dn.size() != 0) begin errors++; $display("FAIL repeat_down got %0d exp 0", q_dn.size()); end
        end
    endtask

    task automatic test_both_held();
        int h;
        int s;
        apply_reset();
        enter_items(2);
        q_up.delete();
        q_dn.delete();
        h = int'($urandom_range(10, 50));
        s = int'($urandom_range(0, 10));
        btn_up = 1'b1;
        btn_down = 1'b1;
        step(h);
        btn_up = 1'b0;
        step(s);
        btn_down = 1'b0;
        step(20);
        checks++;
        if (q_up.size() != 0 || q_dn.size() != 0) begin
            errors++; $display("FAIL both_held got up=%0d dn=%0d exp 0/0", q_up.size(), q_dn.size());
        end
    endtask

    task automatic test_run_and_mode_up();
        int m;
        apply_reset();
        press(1, 8, 15, m);
        press(2, 8, 15, m);
        checks++;
        if (q_up.size() != 0 || q_dn.size() != 0 || blink !== 1'b0) begin
            errors++; $display("FAIL run_press got up=%0d dn=%0d bl=%b exp 0/0/0", q_up.size(), q_dn.size(), blink);
        end
        enter_items(1);
        q_up.delete();
        btn_mode = 1'b1;
        btn_up = 1'b1;
        step(8);
        btn_mode = 1'b0;
        btn_up = 1'b0;
        step(15);
        checks++;
        if (select_item !== 3'd1 || q_up.size() != 0) begin
            errors++; $display("FAIL mode_with_up got item=%0d up=%0d exp 1/0", select_item, q_up.size());
        end
    endtask

    task automatic test_timeout();
        int r;
        apply_reset();
        btn_mode = 1'b1;
        step(8);
        btn_mode = 1'b0;
        r = cyc;
        step(1 + (2 + D) + TO - 1 - (cyc - r));
        checks++;
        if (editing !== 1'b1 || select_item !== 3'd0) begin
            errors++; $display("FAIL timeout_early got ed=%b item=%0d exp 1/0", editing, select_item);
        end
        step(1);
        checks++;
        if (select_item !== 3'd7 || editing !== 1'b0 || blink !== 1'b0) begin
            errors++; $display("FAIL timeout got item=%0d ed=%b bl=%b exp 7/0/0", select_item, editing, blink);
        end
    endtask

    task automatic test_reset_hold();
        int m;
        apply_reset();
        enter_items(1);
        btn_up = 1'b1;
        step(30);
        rst_n = 1'b0;
        #2;
        checks++;
        if (select_item !== 3'd7 || up !== 1'b0 || down !== 1'b0 || editing !== 1'b0 || blink !== 1'b0) begin
            errors++; $display("FAIL reset_hold_async got item=%0d up=%b dn=%b ed=%b bl=%b exp 7/0/0/0/0",
                               select_item, up, down, editing, blink);
        end
        step(1);
        rst_n = 1'b1;
        q_up.delete();
        q_dn.delete();
        step(30);
        press(0, 8, 40, m);
        checks++;
        if (q_up.size() != 0 || select_item !== 3'd0) begin
            errors++; $display("FAIL reset_hold_reenter got up=%0d item=%0d exp 0/0", q_up.size(), select_item);
        end
        btn_up = 1'b0;
        step(15);
        press(1, 8, 20, m);
        checks++;
        if (q_up.size() != 1) begin
            errors++; $display("FAIL reset_hold_press got %0d exp 1", q_up.size());
        end else begin
            checks++;
            if (q_up[0] != m + 1 + LAT) begin errors++; $display("FAIL reset_hold_time got %0d exp %0d", q_up[0], m + 1 + LAT); end
        end
    endtask

    task automatic test_random();
        int m;
        int b;
        int item;
        int exp_up[$];
        int exp_dn[$];
        apply_reset();
        item = 7;
        for (int n = 0; n < 16; n++) begin
            b = int'($urandom_range(0, 2));
            press(b, int'($urandom_range(D + 2, 12)), int'($urandom_range(D + 5, 16)), m);
            if (b == 0) begin
                item = next_item(item);
                checks++;
                if (select_item !== 3'(item)) begin errors++; $display("FAIL rand_item n=%0d got %0d exp %0d", n, select_item, item); end
            end else if (item != 7) begin
                if (b == 1) exp_up.push_back(m + 1 + LAT);
                else        exp_dn.push_back(m + 1 + LAT);
            end
        end
        checks++;
        if (q_up.size() != exp_up.size() || q_dn.size() != exp_dn.size()) begin
            errors++; $display("FAIL rand_counts got up=%0d dn=%0d exp %0d/%0d", q_up.size(), q_dn.size(), exp_up.size(), exp_dn.size());
        end
        for (int i = 0; i < exp_up.size() && i < q_up.size(); i++) begin
            checks++;
            if (q_up[i] != exp_up[i]) begin errors++; $display("FAIL rand_up i=%0d got %0d exp %0d", i, q_up[i], exp_up[i]); end
        end
        for (int i = 0; i < exp_dn.size() && i < q_dn.size(); i++) begin
            checks++;
            if (q_dn[i] != exp_dn[i]) begin errors++; $display("FAIL rand_dn i=%0d got %0d exp %0d", i, q_dn[i], exp_dn[i]); end
        end
    endtask

    task automatic test_exclusive();
        checks++;
        if (both_seen != 0) begin errors++; $display("FAIL up_down_exclusive got %0d overlaps exp 0", both_seen); end
    endtask

    initial begin
        step(1);
        test_reset();
        test_mode_step();
        test_glitch_press();
        test_repeat();
        test_both_held();
        test_run_and_mode_up();
        test_timeout();
        test_reset_hold();
        test_random();
        test_exclusive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
